bp_me_dma_bank_mux: RTL and testbench

//  Multi-bank successor to the single-L2 DMA path of the unicore. It merges the bsg_cache DMA

---
 rtl/bp_me_dma_bank_mux.sv | 202 ++++++++++++++++++++
 tb/tb_bp_me_dma_bank_mux.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_dma_bank_mux.sv
// Merges the bsg_cache DMA ports of num_banks_p L2 banks onto a single DRAM-side DMA port.
// Optional macro BP_DMA_MUX_WRITE_PRIORITY_EN: eligible write packets win over eligible reads.
module bp_me_dma_bank_mux #(
  parameter int num_banks_p    = 2,
  parameter int addr_width_p   = 28,
  parameter int fill_width_p   = 64,
  parameter int block_width_p  = 512,
  parameter int tag_fifo_els_p = 4
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,

  input  logic [num_banks_p*(addr_width_p+1)-1:0]  bank_dma_pkt_i,
  input  logic [num_banks_p-1:0]                   bank_dma_pkt_v_i,
  output logic [num_banks_p-1:0]                   bank_dma_pkt_yumi_o,

  output logic [num_banks_p*fill_width_p-1:0]      bank_dma_data_o,
  output logic [num_banks_p-1:0]                   bank_dma_data_v_o,
  input  logic [num_banks_p-1:0]                   bank_dma_data_ready_and_i,

  input  logic [num_banks_p*fill_width_p-1:0]      bank_dma_data_i,
  input  logic [num_banks_p-1:0]                   bank_dma_data_v_i,
  output logic [num_banks_p-1:0]                   bank_dma_data_yumi_o,

  output logic [addr_width_p:0]                    dma_pkt_o,
  output logic                                     dma_pkt_v_o,
  input  logic                                     dma_pkt_yumi_i,

  input  logic [fill_width_p-1:0]                  dma_data_i,
  input  logic                                     dma_data_v_i,
  output logic                                     dma_data_ready_and_o,

  output logic [fill_width_p-1:0]                  dma_data_o,
  output logic                                     dma_data_v_o,
  input  logic                                     dma_data_yumi_i
);

  localparam int lg_banks_lp  = (num_banks_p > 1) ? $clog2(num_banks_p) : 1;
  localparam int pkt_width_lp = addr_width_p + 1;
  localparam int beats_lp     = block_width_p / fill_width_p;
  localparam int ptr_w_lp     = (tag_fifo_els_p > 1) ? $clog2(tag_fifo_els_p) : 1;
  localparam int cnt_w_lp     = $clog2(tag_fifo_els_p + 1);

  typedef enum logic {FIFO_RD = 1'b0, FIFO_WR = 1'b1} fifo_e;

  typedef struct packed {
    logic                   found;
    logic [lg_banks_lp-1:0] id;
  } pick_s;

  logic [pkt_width_lp-1:0] pkt_arr [num_banks_p];
  logic [fill_width_p-1:0] wb_arr  [num_banks_p];
  logic [num_banks_p-1:0]  pkt_wr, elig;

  for (genvar i = 0; i < num_banks_p; i++) begin : g_unpack
    assign pkt_arr[i] = bank_dma_pkt_i[i*pkt_width_lp +: pkt_width_lp];
    assign wb_arr[i]  = bank_dma_data_i[i*fill_width_p +: fill_width_p];
    assign pkt_wr[i]  = pkt_arr[i][addr_width_p];
  end

  logic [1:0]             fifo_push, fifo_pop, fifo_v, fifo_full;
  logic [lg_banks_lp-1:0] fifo_head [2];
  logic [lg_banks_lp-1:0] grant_id, lock_id_r, rr_ptr_r;
  logic                   grant_v, grant_wr, lock_v_r, pkt_hs;
  pick_s                  arb;

  // First eligible bank at or after ptr, wrapping around.
  function automatic pick_s rr_pick(input logic [num_banks_p-1:0] req,
                                    input logic [lg_banks_lp-1:0] ptr);
    pick_s p;
    int    idx;
    p = '0;
    for (int i = 0; i < num_banks_p; i++) begin
      idx = int'(ptr) + i;
      if (idx >= num_banks_p) idx -= num_banks_p;
      if (!p.found && req[lg_banks_lp'(idx)]) begin
        p.found = 1'b1;
        p.id    = lg_banks_lp'(idx);
      end
    end
    return p;
  endfunction

  for (genvar i = 0; i < num_banks_p; i++) begin : g_elig
    assign elig[i] = bank_dma_pkt_v_i[i] & (pkt_wr[i] ? ~fifo_full[FIFO_WR] : ~fifo_full[FIFO_RD]);
  end

  always_comb begin
`ifdef BP_DMA_MUX_WRITE_PRIORITY_EN
    arb = rr_pick(elig & pkt_wr, rr_ptr_r);
    if (!arb.found) arb = rr_pick(elig & ~pkt_wr, rr_ptr_r);
`else
    arb = rr_pick(elig, rr_ptr_r);
`endif
  end

  // A locked grant keeps the presented packet stable until the DRAM side takes it.
  assign grant_id  = lock_v_r ? lock_id_r : arb.id;
  assign grant_v   = ~reset_i & (lock_v_r ? bank_dma_pkt_v_i[lock_id_r] : arb.found);
  assign grant_wr  = pkt_arr[grant_id][addr_width_p];
  assign pkt_hs    = grant_v & dma_pkt_yumi_i;

  assign dma_pkt_o   = grant_v ? pkt_arr[grant_id] : '0;
  assign dma_pkt_v_o = grant_v;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    bank_dma_pkt_yumi_o           = '0;
    bank_dma_pkt_yumi_o[grant_id] = pkt_hs;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_r  <= '0;
      lock_v_r  <= 1'b0;
      lock_id_r <= '0;
    end else if (pkt_hs) begin
      lock_v_r <= 1'b0;
      rr_ptr_r <= (grant_id == lg_banks_lp'(num_banks_p-1)) ? '0 : grant_id + lg_banks_lp'(1);
    end else if (grant_v) begin
      lock_v_r  <= 1'b1;
      lock_id_r <= grant_id;
    end
  end

  assign fifo_push[FIFO_RD] = pkt_hs & ~grant_wr;
  assign fifo_push[FIFO_WR] = pkt_hs &  grant_wr;

  for (genvar f = 0; f < 2; f++) begin : g_id_fifo
    logic [lg_banks_lp-1:0] mem_r [tag_fifo_els_p];
    logic [ptr_w_lp-1:0]    rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0]    cnt_r;

    // NOTE: id storage is not reset; the count alone says which entries are live.
    always_ff @(posedge clk_i) begin
      if (fifo_push[f]) mem_r[wr_ptr_r] <= grant_id;
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
        cnt_r    <= '0;
      end else begin
        if (fifo_push[f])
          wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(tag_fifo_els_p-1)) ? '0 : wr_ptr_r + ptr_w_lp'(1);
        if (fifo_pop[f])
          rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(tag_fifo_els_p-1)) ? '0 : rd_ptr_r + ptr_w_lp'(1);
        cnt_r <= cnt_r + cnt_w_lp'(fifo_push[f]) - cnt_w_lp'(fifo_pop[f]);
      end
    end

    assign fifo_v[f]    = (cnt_r != '0) & ~reset_i;
    assign fifo_full[f] = (cnt_r == cnt_w_lp'(tag_fifo_els_p));
    assign fifo_head[f] = mem_r[rd_ptr_r];
  end

  logic rd_hs, wr_hs, rd_last, wr_last;

  assign bank_dma_data_o      = {num_banks_p{dma_data_i}};
  assign dma_data_ready_and_o = fifo_v[FIFO_RD] & bank_dma_data_ready_and_i[fifo_head[FIFO_RD]];
  assign rd_hs                = dma_data_v_i & dma_data_ready_and_o;
  assign wr_hs                = dma_data_yumi_i & fifo_v[FIFO_WR];
  assign fifo_pop[FIFO_RD]    = rd_hs & rd_last;
  assign fifo_pop[FIFO_WR]    = wr_hs & wr_last;

  always_comb begin
    bank_dma_data_v_o    = '0;
    bank_dma_data_yumi_o = '0;
    dma_data_o           = '0;
    dma_data_v_o         = 1'b0;
    if (fifo_v[FIFO_RD]) bank_dma_data_v_o[fifo_head[FIFO_RD]] = dma_data_v_i;
    if (fifo_v[FIFO_WR]) begin
      dma_data_o                                = wb_arr[fifo_head[FIFO_WR]];
      dma_data_v_o                              = bank_dma_data_v_i[fifo_head[FIFO_WR]];
      bank_dma_data_yumi_o[fifo_head[FIFO_WR]] = dma_data_yumi_i;
    end
  end

  // Beat counters exist only when a block spans several fill beats.
  if (beats_lp > 1) begin : g_cnt
    localparam int bw_lp = $clog2(beats_lp);
    logic [bw_lp-1:0] rd_cnt_r, wr_cnt_r;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rd_cnt_r <= '0;
        wr_cnt_r <= '0;
      end else begin
        if (rd_hs) rd_cnt_r <= rd_last ? '0 : rd_cnt_r + bw_lp'(1);
        if (wr_hs) wr_cnt_r <= wr_last ? '0 : wr_cnt_r + bw_lp'(1);
      end
    end

    assign rd_last = (rd_cnt_r == bw_lp'(beats_lp-1));
    assign wr_last = (wr_cnt_r == bw_lp'(beats_lp-1));
  end else begin : g_no_cnt
    assign rd_last = 1'b1;
    assign wr_last = 1'b1;
  end

endmodule

// File: tb/tb_bp_me_dma_bank_mux.sv
// Self-checking bench for bp_me_dma_bank_mux: directed scenarios plus random traffic,
// all compared against a queue-based transaction model of the merged DMA port.
module tb_bp_me_dma_bank_mux;

  localparam int NB    = 2;
  localparam int AW    = 28;
  localparam int FW    = 64;
  localparam int BW    = 512;
  localparam int ELS   = 4;
  localparam int BEATS = BW / FW;
  localparam int PW    = AW + 1;

  logic              clk, reset_i;
  logic [NB*PW-1:0]  bank_dma_pkt_i;
  logic [NB-1:0]     bank_dma_pkt_v_i, bank_dma_pkt_yumi_o;
  logic [NB*FW-1:0]  bank_dma_data_o;
  logic [NB-1:0]     bank_dma_data_v_o, bank_dma_data_ready_and_i;
  logic [NB*FW-1:0]  bank_dma_data_i;
  logic [NB-1:0]     bank_dma_data_v_i, bank_dma_data_yumi_o;
  logic [PW-1:0]     dma_pkt_o;
  logic              dma_pkt_v_o, dma_pkt_yumi_i;
  logic [FW-1:0]     dma_data_i;
  logic              dma_data_v_i, dma_data_ready_and_o;
  logic [FW-1:0]     dma_data_o;
  logic              dma_data_v_o, dma_data_yumi_i;

  bp_me_dma_bank_mux #(
    .num_banks_p(NB), .addr_width_p(AW), .fill_width_p(FW),
    .block_width_p(BW), .tag_fifo_els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .bank_dma_pkt_i(bank_dma_pkt_i), .bank_dma_pkt_v_i(bank_dma_pkt_v_i),
    .bank_dma_pkt_yumi_o(bank_dma_pkt_yumi_o),
    .bank_dma_data_o(bank_dma_data_o), .bank_dma_data_v_o(bank_dma_data_v_o),
    .bank_dma_data_ready_and_i(bank_dma_data_ready_and_i),
    .bank_dma_data_i(bank_dma_data_i), .bank_dma_data_v_i(bank_dma_data_v_i),
    .bank_dma_data_yumi_o(bank_dma_data_yumi_o),
    .dma_pkt_o(dma_pkt_o), .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i),
    .dma_data_ready_and_o(dma_data_ready_and_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_yumi_i(dma_data_yumi_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bank-side stimulus: each bank holds one pending packet until it is consumed.
  logic [NB-1:0] pend_v;
  logic [PW-1:0] pend_pkt [NB];
  bit            pkt_yumi_en, wb_yumi_en;

  // Reference model: arbitration pointer, held grant, per-type issue queues, beat counts.
  int m_rr, m_lock, m_rd_beat, m_wr_beat;
  int m_rdq[$];
  int m_wrq[$];

  // Observed traffic for the directed scenarios.
  int            grant_log[$];
  logic [PW-1:0] pkt_log[$];
  int            fill_log[$];
  logic [FW-1:0] wb_log[$];

  function automatic int pick(input logic [NB-1:0] req);
    for (int k = 0; k < NB; k++) begin
      int b;
      b = (m_rr + k) % NB;
      if (req[b]) return b;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_lock = -1; m_rd_beat = 0; m_wr_beat = 0;
    m_rdq.delete(); m_wrq.delete();
    pend_v = '0;
  endtask

  task automatic clear_logs();
    grant_log.delete(); pkt_log.delete(); fill_log.delete(); wb_log.delete();
  endtask

  // One clock cycle: drive at negedge, predict, check at +1, update model at posedge.
  task automatic step();
    logic [NB-1:0] el, wmask, e_pkt_yumi, e_fill_v, e_wb_yumi;
    logic [PW-1:0] e_pkt;
    logic [FW-1:0] e_wb_data;
    bit            e_pkt_v, e_ready, e_wb_v;
    int            e_g;
    e_pkt_v = 0; e_ready = 0; e_wb_v = 0; e_g = -1;
    e_pkt = '0; e_wb_data = '0; e_pkt_yumi = '0; e_fill_v = '0; e_wb_yumi = '0;
    for (int b = 0; b < NB; b++) begin
      bank_dma_pkt_v_i[b]          = pend_v[b];
      bank_dma_pkt_i[b*PW +: PW]   = pend_pkt[b];
      wmask[b]                     = pend_pkt[b][PW-1];
      el[b] = pend_v[b] && (wmask[b] ? (m_wrq.size() < ELS) : (m_rdq.size() < ELS));
    end
    if (!reset_i) begin
      if (m_lock >= 0) e_g = m_lock;
      else begin
`ifdef BP_DMA_MUX_WRITE_PRIORITY_EN
        e_g = pick(el & wmask);
        if (e_g < 0) e_g = pick(el & ~wmask);
`else
        e_g = pick(el);
`endif
      end
      if (e_g >= 0) begin
        e_pkt_v = 1;
        e_pkt   = pend_pkt[e_g];
      end
      if (m_rdq.size() > 0) begin
        e_fill_v[m_rdq[0]] = dma_data_v_i;
        e_ready            = bank_dma_data_ready_and_i[m_rdq[0]];
      end
      if (m_wrq.size() > 0) begin
        e_wb_data = bank_dma_data_i[m_wrq[0]*FW +: FW];
        e_wb_v    = bank_dma_data_v_i[m_wrq[0]];
      end
    end
    dma_pkt_yumi_i  = pkt_yumi_en & e_pkt_v;
    dma_data_yumi_i = wb_yumi_en & e_wb_v;
    if (e_pkt_v && dma_pkt_yumi_i) e_pkt_yumi[e_g] = 1'b1;
    if (!reset_i && m_wrq.size() > 0 && dma_data_yumi_i) e_wb_yumi[m_wrq[0]] = 1'b1;
    #1;
    check("pkt_v", dma_pkt_v_o, e_pkt_v);
    if (e_pkt_v) check("pkt", dma_pkt_o, e_pkt);
    check("pkt_yumi", bank_dma_pkt_yumi_o, e_pkt_yumi);
    check("fill_v", bank_dma_data_v_o, e_fill_v);
    check("fill_rdy", dma_data_ready_and_o, e_ready);
    check("fill_data", bank_dma_data_o, {NB{dma_data_i}});
    check("wb_v", dma_data_v_o, e_wb_v);
    if (e_wb_v) check("wb_data", dma_data_o, e_wb_data);
    check("wb_yumi", bank_dma_data_yumi_o, e_wb_yumi);
    if (dma_pkt_v_o && dma_pkt_yumi_i) begin
      grant_log.push_back(e_g);
      pkt_log.push_back(dma_pkt_o);
    end
    if (dma_data_v_i && dma_data_ready_and_o)
      for (int b = 0; b < NB; b++) if (bank_dma_data_v_o[b]) fill_log.push_back(b);
    if (dma_data_yumi_i) wb_log.push_back(dma_data_o);
    @(posedge clk);
    if (reset_i) model_reset();
    else begin
      if (dma_data_v_i && e_ready) begin
        m_rd_beat++;
        if (m_rd_beat == BEATS) begin m_rd_beat = 0; void'(m_rdq.pop_front()); end
      end
      if (dma_data_yumi_i && m_wrq.size() > 0) begin
        m_wr_beat++;
        if (m_wr_beat == BEATS) begin m_wr_beat = 0; void'(m_wrq.pop_front()); end
      end
      if (e_pkt_v && dma_pkt_yumi_i) begin
        if (pend_pkt[e_g][PW-1]) m_wrq.push_back(e_g);
        else                     m_rdq.push_back(e_g);
        m_rr       = (e_g + 1) % NB;
        m_lock     = -1;
        pend_v[e_g] = 1'b0;
      end else if (e_pkt_v) m_lock = e_g;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pend_v = '0;
    bank_dma_data_ready_and_i = '0; bank_dma_data_v_i = '0; bank_dma_data_i = '0;
    dma_data_i = '0; dma_data_v_i = 1'b0;
    pkt_yumi_en = 0; wb_yumi_en = 0;
  endtask

  task automatic do_reset(input int n);
    reset_i = 1'b1;
    idle_inputs();
    repeat (n) step();
    reset_i = 1'b0;
    clear_logs();
  endtask

  task automatic refill_reads();
    for (int b = 0; b < NB; b++)
      if (!pend_v[b]) begin
        pend_v[b]   = 1'b1;
        pend_pkt[b] = {1'b0, AW'(32'h1000 + b*16 + $urandom_range(0, 15))};
      end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int b = 0; b < NB; b++) pend_pkt[b] = '0;
    reset_i = 1'b1;
    idle_inputs();
    dma_pkt_yumi_i = 1'b0; dma_data_yumi_i = 1'b0;
    bank_dma_pkt_i = '0; bank_dma_pkt_v_i = '0;
    model_reset();
    @(negedge clk);
    do_reset(2);

    // Reset state with idle banks.
    step();
    check("rst_pkt_v", dma_pkt_v_o, 0);
    check("rst_fill_rdy", dma_data_ready_and_o, 0);
    check("rst_wb_v", dma_data_v_o, 0);

    // Two reads issue in RR order; fills steer 8 beats to each bank in issue order.
    pend_v = 2'b11;
    pend_pkt[0] = {1'b0, 28'h100};
    pend_pkt[1] = {1'b0, 28'h200};
    pkt_yumi_en = 1;
    bank_dma_data_ready_and_i = 2'b11;
    repeat (3) step();
    check("t1_ngrant", grant_log.size(), 2);
    check("t1_pkt0", pkt_log[0], {1'b0, 28'h100});
    check("t1_pkt1", pkt_log[1], {1'b0, 28'h200});
    dma_data_v_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dma_data_i = {$urandom, $urandom};
      step();
    end
    check("t1_nfill", fill_log.size(), 16);
    for (int i = 0; i < 16; i++) check("t1_fill_bank", fill_log[i], (i < 8) ? 0 : 1);

    // A stalled grant stays locked even when a higher-priority bank appears.
    do_reset(1);
    pend_v[1] = 1'b1;
    pend_pkt[1] = {1'b0, 28'h300};
    step();
    pend_v[0] = 1'b1;
    pend_pkt[0] = {1'b0, 28'h400};
    repeat (4) step();
    check("t2_hold_v", dma_pkt_v_o, 1);
    check("t2_hold_pkt", dma_pkt_o, {1'b0, 28'h300});
    pkt_yumi_en = 1;
    dma_data_v_i = 1'b1;
    bank_dma_data_ready_and_i = 2'b11;
    repeat (12) begin refill_reads(); step(); end
    check("t2_ngrant", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) check("t2_alt", grant_log[i], (i % 2 == 0) ? 1 : 0);

    // Writeback beats flow only after the write packet is consumed, only from bank1.
    do_reset(1);
    pend_v[1] = 1'b1;
    pend_pkt[1] = {1'b1, 28'h500};
    bank_dma_data_v_i = 2'b11;
    wb_yumi_en = 1;
    repeat (3) step();
    check("t3_early_wb", wb_log.size(), 0);
    pkt_yumi_en = 1;
    repeat (12) begin
      bank_dma_data_i[0 +: FW]  = 64'hdead;
      bank_dma_data_i[FW +: FW] = FW'(10 + wb_log.size());
      step();
    end
    check("t3_nwb", wb_log.size(), 8);
    for (int i = 0; i < 8; i++) check("t3_wb", wb_log[i], 10 + i);

    // Full read id FIFO blocks the fifth read until the first fill completes.
    do_reset(1);
    pkt_yumi_en = 1;
    bank_dma_data_ready_and_i = 2'b11;
    repeat (10) begin refill_reads(); step(); end
    check("t4_ngrant", grant_log.size(), 4);
    check("t4_blocked", dma_pkt_v_o, 0);
    dma_data_v_i = 1'b1;
    repeat (8) begin refill_reads(); step(); end
    check("t4_still4", grant_log.size(), 4);
    check("t4_regrant_v", dma_pkt_v_o, 1);
    dma_data_v_i = 1'b0;
    step();
    check("t4_fifth", grant_log.size(), 5);

    // Reset mid-fill abandons the burst; the next fill starts at beat 0.
    do_reset(1);
    pend_v[0] = 1'b1;
    pend_pkt[0] = {1'b0, 28'h80};
    pkt_yumi_en = 1;
    bank_dma_data_ready_and_i = 2'b11;
    repeat (2) step();
    dma_data_v_i = 1'b1;
    repeat (3) step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("t5_fill_v", bank_dma_data_v_o, 0);
    check("t5_rdy", dma_data_ready_and_o, 0);
    clear_logs();
    pend_v[1] = 1'b1;
    pend_pkt[1] = {1'b0, 28'h90};
    repeat (10) step();
    check("t5_nfill", fill_log.size(), 8);
    for (int i = 0; i < 8; i++) check("t5_fill_bank", fill_log[i], 1);
    check("t5_done_rdy", dma_data_ready_and_o, 0);

    // Read on bank0 and write on bank1 arriving together.
    do_reset(1);
    pend_v = 2'b11;
    pend_pkt[0] = {1'b0, 28'h600};
    pend_pkt[1] = {1'b1, 28'h700};
    step();
`ifdef BP_DMA_MUX_WRITE_PRIORITY_EN
    check("t6_grant", dma_pkt_o, {1'b1, 28'h700});
`else
    check("t6_grant", dma_pkt_o, {1'b0, 28'h600});
`endif

    // Random traffic on every port.
    do_reset(1);
    repeat (3000) begin
      for (int b = 0; b < NB; b++)
        if (!pend_v[b] && $urandom_range(0, 2) == 0) begin
          pend_v[b]   = 1'b1;
          pend_pkt[b] = {1'($urandom_range(0, 1)), AW'($urandom)};
        end
      bank_dma_data_ready_and_i = NB'($urandom);
      bank_dma_data_v_i         = NB'($urandom);
      for (int b = 0; b < NB; b++) bank_dma_data_i[b*FW +: FW] = {$urandom, $urandom};
      dma_data_i   = {$urandom, $urandom};
      dma_data_v_i = ($urandom_range(0, 3) != 0);
      pkt_yumi_en  = 1'($urandom_range(0, 1));
      wb_yumi_en   = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
